// File: rtl/tsc_pkg.sv
// Shared TSC definitions: ISA encodings, FSM states and word size.
package tsc_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/tsc_alu.sv
// Combinational TSC ALU: data result for ALU/immediate ops plus the branch flag.
module tsc_alu
  import tsc_pkg::*;
(
  input  logic [3:0]           i_op,
  input  logic [5:0]           i_func,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result,
  output logic                 o_branch
);

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    o_result = '0;
    o_branch = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_ADD:  o_result = i_a + i_b;
          FN_SUB:  o_result = i_a - i_b;
          FN_AND:  o_result = i_a & i_b;
          FN_ORR:  o_result = i_a | i_b;
          FN_NOT:  o_result = ~i_a;
          FN_TCP:  o_result = ~i_a + 16'd1;
          FN_SHL:  o_result = {i_a[WORD_SIZE-2:0], 1'b0};
          FN_SHR:  o_result = {i_a[WORD_SIZE-1], i_a[WORD_SIZE-1:1]};
          default: o_result = '0;
        endcase
      end
      // b already carries the extended immediate for I-type ops
      OP_ADI:  o_result = i_a + i_b;
      OP_ORI:  o_result = i_a | i_b;
      OP_LHI:  o_result = i_b;
      OP_BNE:  o_branch = (i_a != i_b);
      OP_BEQ:  o_branch = (i_a == i_b);
      OP_BGZ:  o_branch = !i_a[WORD_SIZE-1] && (i_a != '0);
      OP_BLZ:  o_branch = i_a[WORD_SIZE-1];
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/tsc_multicycle_cpu.sv
// Multi-cycle TSC core with a FETCH/EXEC/HALT FSM and external fetch handshake.
// Optional retired-instruction counter port num_inst under `TSC_INST_COUNT_EN.
module tsc_multicycle_cpu
  import tsc_pkg::*;
#(
  parameter int                 PC_SIZE  = 16,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset_cpu_n,
  input  logic                 cpu_enable,
  output logic                 i_req,
  output logic [PC_SIZE-1:0]   i_addr,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_valid,
  input  logic                 wwd_enable,
  input  logic [1:0]           register_selection,
  output logic [WORD_SIZE-1:0] output_port,
  output logic [7:0]           PC_below8bit,
  output logic                 halted
`ifdef TSC_INST_COUNT_EN
  ,
  output logic [15:0]          num_inst
`endif
);

  state_t               r_state, w_state_nxt;
  logic [PC_SIZE-1:0]   r_pc;
  logic [WORD_SIZE-1:0] r_ir, r_wwd;
  logic [WORD_SIZE-1:0] r_regs [4];

  logic [3:0]           w_op;
  logic [5:0]           w_func;
  logic [7:0]           w_imm;
  logic [WORD_SIZE-1:0] w_rs, w_rt, w_imm_sext, w_alu_b, w_alu_y, w_link, w_wd;
  logic [PC_SIZE-1:0]   w_pc_inc, w_pc_br, w_pc_jmp, w_pc_nxt;
  logic [1:0]           w_wa;
  logic                 w_branch, w_fetch, w_commit, w_we, w_wwd_we, w_is_hlt;

  assign w_op       = r_ir[15:12];
  assign w_func     = r_ir[5:0];
  assign w_imm      = r_ir[7:0];
  assign w_rs       = r_regs[r_ir[11:10]];
  assign w_rt       = r_regs[r_ir[9:8]];
  assign w_imm_sext = sext8(w_imm);
  assign w_pc_inc   = r_pc + 1'b1;
  assign w_pc_br    = w_pc_inc + w_imm_sext[PC_SIZE-1:0];
  assign w_link     = WORD_SIZE'(w_pc_inc);

  generate
    if (PC_SIZE > 12) begin : g_jmp_wide
      assign w_pc_jmp = {r_pc[PC_SIZE-1:12], r_ir[11:0]};
    end else begin : g_jmp_narrow
      assign w_pc_jmp = r_ir[PC_SIZE-1:0];
    end
  endgenerate

  always_comb begin
    w_alu_b = w_rt;
    case (w_op)
      OP_ADI:  w_alu_b = w_imm_sext;
      OP_ORI:  w_alu_b = {8'h00, w_imm};
      OP_LHI:  w_alu_b = {w_imm, 8'h00};
      default: w_alu_b = w_rt;
    endcase
  end

  tsc_alu u_alu (
    .i_op     (w_op),
    .i_func   (w_func),
    .i_a      (w_rs),
    .i_b      (w_alu_b),
    .o_result (w_alu_y),
    .o_branch (w_branch)
  );

  // Writeback and next-pc selection for the instruction held in ir.
  always_comb begin
    w_pc_nxt = w_pc_inc;
    w_we     = 1'b0;
    w_wa     = r_ir[7:6];
    w_wd     = w_alu_y;
    w_wwd_we = 1'b0;
    w_is_hlt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_func)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: w_we = 1'b1;
          FN_WWD: w_wwd_we = 1'b1;
          FN_JPR: w_pc_nxt = w_rs[PC_SIZE-1:0];
          FN_JRL: begin
            w_pc_nxt = w_rs[PC_SIZE-1:0];
            w_we     = 1'b1;
            w_wa     = 2'd2;
            w_wd     = w_link;
          end
          FN_HLT: begin
            w_pc_nxt = r_pc;
            w_is_hlt = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ADI, OP_ORI, OP_LHI: begin
        w_we = 1'b1;
        w_wa = r_ir[9:8];
      end
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: if (w_branch) w_pc_nxt = w_pc_br;
      OP_JMP: w_pc_nxt = w_pc_jmp;
      OP_JAL: begin
        w_pc_nxt = w_pc_jmp;
        w_we     = 1'b1;
        w_wa     = 2'd2;
        w_wd     = w_link;
      end
      default: ;
    endcase
  end

  // Reset gates i_req so a request drops the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    i_req       = 1'b0;
    halted      = 1'b0;
    case (r_state)
      FETCH: begin
        i_req = cpu_enable & reset_cpu_n;
        if (cpu_enable && i_valid) w_state_nxt = EXEC;
      end
      EXEC:    if (cpu_enable) w_state_nxt = w_is_hlt ? HALT : FETCH;
      HALT:    halted = 1'b1;
      default: w_state_nxt = FETCH;
    endcase
  end

  assign w_fetch  = i_req & i_valid;
  assign w_commit = (r_state == EXEC) && cpu_enable;

  // NOTE: non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_wwd   <= '0;
      // NOTE: the register file is four flops with visible reset values, so it is reset; a RAM would not be.
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch) r_ir <= i_data;
      if (w_commit) begin
        r_pc <= w_pc_nxt;
        if (w_we)     r_regs[w_wa] <= w_wd;
        if (w_wwd_we) r_wwd        <= w_rs;
      end
    end
  end

`ifdef TSC_INST_COUNT_EN
  always_ff @(posedge clk or negedge reset_cpu_n) begin
    if (!reset_cpu_n)  num_inst <= '0;
    else if (w_commit) num_inst <= num_inst + 16'd1;
  end
`endif

  assign i_addr       = r_pc;
  assign PC_below8bit = r_pc[7:0];
  assign output_port  = wwd_enable ? r_wwd : r_regs[register_selection];

endmodule
